// File: rtl/alu_operand_stage.sv
// Registered operand-issue stage feeding the 8-bit bitwise units: a main + skid
// buffer that sustains one transfer per cycle with a registered in_ready.
module alu_operand_stage #(
    parameter int WIDTH = 8,
    parameter int OPW   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [OPW-1:0]   out_op,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a held valid keeps its data stable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic [OPW-1:0]   skid_op;
    logic             acc;
    logic             drn;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign state_dbg = state;

    // The main register takes fresh input whenever it is free or drained in the
    // same cycle; the skid only catches a pair that arrives while main is stalled.
    assign load_main_in   = acc & ((state == ST_EMPTY) | ((state == ST_ONE) & drn));
    assign load_main_skid = (state == ST_FULL) & drn;
    assign load_skid      = acc & (state == ST_ONE) & ~drn;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (acc) state_nxt = ST_ONE;
            end
            ST_ONE: begin
                if (acc && !drn)      state_nxt = ST_FULL;
                else if (!acc && drn) state_nxt = ST_EMPTY;
                else                  state_nxt = ST_ONE;
            end
            ST_FULL: begin
                if (drn) state_nxt = ST_ONE;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            skid_a    <= '0;
            skid_b    <= '0;
            skid_op   <= '0;
            issue_cnt <= '0;
        end else begin
            state    <= state_nxt;
            // Ready looks one cycle ahead so it never depends on this cycle's inputs.
            in_ready <= (state_nxt != ST_FULL);

            if (load_main_in) begin
                out_a  <= in_a;
                out_b  <= in_b;
                out_op <= in_op;
            end else if (load_main_skid) begin
                out_a  <= skid_a;
                out_b  <= skid_b;
                out_op <= skid_op;
            end

            if (load_skid) begin
                skid_a  <= in_a;
                skid_b  <= in_b;
                skid_op <= in_op;
            end

            if (drn) issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, reset/stream corner cases,
// random traffic against a queue-based model, and a narrow-counter wrap instance.
module tb_alu_operand_stage;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [1:0]  out_op;
    logic [15:0] issue_cnt;
    logic [1:0]  state_dbg;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_a2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out_a2;
    logic [7:0]  out_b2;
    logic [1:0]  out_op2;
    logic [3:0]  issue_cnt2;
    logic [1:0]  state_dbg2;

    always #5 clk = ~clk;

    alu_operand_stage #(.WIDTH(8), .OPW(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .issue_cnt(issue_cnt), .state_dbg(state_dbg)
    );

    alu_operand_stage #(.WIDTH(8), .OPW(2), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(~in_a2), .in_op(2'b10),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_a(out_a2), .out_b(out_b2), .out_op(out_op2),
        .issue_cnt(issue_cnt2), .state_dbg(state_dbg2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: pairs in flight, packed {op, b, a}; the head is what must be on out_*.
    logic [17:0] exp_q[$];
    logic [17:0] m_last;
    logic        m_ready;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last  = '0;
        m_ready = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic model_check();
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        chk("out_a", {24'd0, out_a}, {24'd0, m_last[7:0]});
        chk("out_b", {24'd0, out_b}, {24'd0, m_last[15:8]});
        chk("out_op", {30'd0, out_op}, {30'd0, m_last[17:16]});
        chk("issue_cnt", {16'd0, issue_cnt}, {16'd0, m_cnt});
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
    endtask

    // Drive inputs for the coming edge and advance the model by that edge.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic ordy);
        logic acc;
        logic drn;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        acc = v & m_ready;
        drn = (exp_q.size() > 0) & ordy;
        if (drn) begin
            void'(exp_q.pop_front());
            m_cnt++;
        end
        if (acc) exp_q.push_back({op, b, a});
        m_ready = (exp_q.size() != 2);
        if (exp_q.size() > 0) m_last = exp_q[0];
    endtask

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       ordy;
        logic       e_vld;
        logic       e_rdy;
        logic [1:0] e_st;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic [1:0] e_op;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Each row: inputs driven at this negedge, expectations observed before driving.
        tbl[0]  = '{1'b1, 8'hA5, 8'h0F, 2'd1, 1'b1, 1'b0, 1'b1, S_EMPTY, 8'h00, 8'h00, 2'd0, 16'd0};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, S_ONE,   8'hA5, 8'h0F, 2'd1, 16'd0};
        tbl[2]  = '{1'b1, 8'h11, 8'hEE, 2'd0, 1'b0, 1'b0, 1'b1, S_EMPTY, 8'hA5, 8'h0F, 2'd1, 16'd1};
        tbl[3]  = '{1'b1, 8'h22, 8'hDD, 2'd3, 1'b0, 1'b1, 1'b1, S_ONE,   8'h11, 8'hEE, 2'd0, 16'd1};
        tbl[4]  = '{1'b1, 8'h33, 8'hCC, 2'd1, 1'b0, 1'b1, 1'b0, S_FULL,  8'h11, 8'hEE, 2'd0, 16'd1};
        tbl[5]  = '{1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, S_FULL,  8'h11, 8'hEE, 2'd0, 16'd1};
        tbl[6]  = '{1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, S_ONE,   8'h22, 8'hDD, 2'd3, 16'd2};
        tbl[7]  = '{1'b1, 8'h44, 8'hBB, 2'd2, 1'b0, 1'b0, 1'b1, S_EMPTY, 8'h22, 8'hDD, 2'd3, 16'd3};
        tbl[8]  = '{1'b1, 8'h55, 8'hAA, 2'd0, 1'b1, 1'b1, 1'b1, S_ONE,   8'h44, 8'hBB, 2'd2, 16'd3};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, S_ONE,   8'h55, 8'hAA, 2'd0, 16'd4};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, S_EMPTY, 8'h55, 8'hAA, 2'd0, 16'd5};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_a2 = '0; out_ready2 = 1'b1;
        model_reset();

        // Power-on reset values.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_a", {24'd0, out_a}, 32'd0);
        chk("rst_cnt", {16'd0, issue_cnt}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);

        // Directed table: single issue, back-pressure into FULL, acc&drn in ONE.
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[k].e_vld});
            chk("tbl_ready", {31'd0, in_ready}, {31'd0, tbl[k].e_rdy});
            chk("tbl_state", {30'd0, state_dbg}, {30'd0, tbl[k].e_st});
            chk("tbl_a", {24'd0, out_a}, {24'd0, tbl[k].e_a});
            chk("tbl_b", {24'd0, out_b}, {24'd0, tbl[k].e_b});
            chk("tbl_op", {30'd0, out_op}, {30'd0, tbl[k].e_op});
            chk("tbl_cnt", {16'd0, issue_cnt}, {16'd0, tbl[k].e_cnt});
            if (k == 1) chk("or_result", {24'd0, out_a | out_b}, 32'hAF);
            drive(tbl[k].v, tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].ordy);
        end

        // Reset asserted mid-cycle while FULL clears everything immediately.
        tick(); drive(1'b1, 8'h11, 8'h01, 2'd1, 1'b0);
        tick(); drive(1'b1, 8'h22, 8'h02, 2'd2, 1'b0);
        tick();
        chk("full_before_rst", {30'd0, state_dbg}, {30'd0, S_FULL});
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_a", {24'd0, out_a}, 32'd0);
        chk("midrst_cnt", {16'd0, issue_cnt}, 32'd0);
        chk("midrst_state", {30'd0, state_dbg}, {30'd0, S_EMPTY});
        model_reset();
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        tick();
        chk("ready_after_release", {31'd0, in_ready}, 32'd1);

        // Streaming: 100 back-to-back transfers, a=i, b=~i.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 8'(i), ~8'(i), 2'(i), 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        tick();
        chk("stream_cnt", {16'd0, issue_cnt}, 32'd100);
        chk("stream_last_a", {24'd0, out_a}, 32'd99);
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
            tick();
        end
        chk("random_drained", {31'd0, out_valid}, 32'd0);

        // Counter wrap on the 4-bit instance: 17 transfers leave issue_cnt at 1.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("w4_ready", {31'd0, in_ready2}, 32'd1);
        for (int i = 0; i < 17; i++) begin
            in_valid2 = 1'b1;
            in_a2     = 8'(i);
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("w4_wrap_cnt", {28'd0, issue_cnt2}, 32'd1);
        chk("w4_last_a", {24'd0, out_a2}, 32'd16);
        chk("w4_empty", {31'd0, out_valid2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
